// File: rtl/tick_receiver_pkg.sv
// Shared defaults and types for the divided-clock tick receiver.
// Channel indices match the divider's fan-out order.
package tick_receiver_pkg;

  localparam int N_CH_DEF    = 6;
  localparam int CNT_W_DEF   = 28;
  localparam int TIMEOUT_DEF = 268435455;

  typedef enum int {
    CH_LED   = 0,
    CH_SNAKE = 1,
    CH_SEG   = 2,
    CH_CNT   = 3,
    CH_I     = 4,
    CH_F     = 5
  } ch_idx_e;

  typedef logic [1:0] settle_t;

  localparam settle_t SETTLE_DONE = 2'd3;

  typedef struct packed {
    logic s1;
    logic s2;
    logic s3;
  } sync_t;

endpackage

// File: rtl/tick_receiver_ch.sv
// One rate channel: synchroniser, rise detect, period counter,
// armed/valid tracking and stall timeout.
module tick_rx_ch
  import tick_receiver_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             settled,
  input  logic             ch_in,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             per_vld,
  output logic             stall
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);

  sync_t            sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             armed_q, armed_d;
  logic             tick_q, tick_d;
  logic             vld_q, vld_d;
  logic             stall_q, stall_d;
  logic             rise;

  always_comb begin
    sync_d   = '{s1: ch_in, s2: sync_q.s1, s3: sync_q.s2};
    rise     = sync_q.s2 & ~sync_q.s3 & settled;
    cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX
                                  : cnt_q + CNT_W'(1);
    cnt_d    = cnt_inc;
    period_d = period_q;
    armed_d  = armed_q;
    vld_d    = vld_q;
    stall_d  = stall_q;
    tick_d   = rise;
    if (rise) begin
      cnt_d   = '0;
      armed_d = 1'b1;
      stall_d = 1'b0;
      // First rise only arms; a period needs two edges.
      if (armed_q) begin
        period_d = cnt_inc;
        vld_d    = 1'b1;
      end
    end else if (cnt_q == TO_M1) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      armed_q  <= 1'b0;
      tick_q   <= 1'b0;
      vld_q    <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      armed_q  <= armed_d;
      tick_q   <= tick_d;
      vld_q    <= vld_d;
      stall_q  <= stall_d;
    end
  end

  assign tick    = tick_q;
  assign period  = period_q;
  assign per_vld = vld_q;
  assign stall   = stall_q;

endmodule

// File: rtl/tick_receiver.sv
// Receives N slow rate signals into clk and emits one-cycle ticks,
// period measurements and stall flags per channel.
module tick_receiver
  import tick_receiver_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       ch_in,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH*CNT_W-1:0] period,
  output logic [N_CH-1:0]       per_vld,
  output logic [N_CH-1:0]       stall
);

  settle_t settle_q, settle_d;
  logic    settled;

  // Masks edges that are only sync-chain fill after reset release.
  always_comb begin
    settled  = (settle_q == SETTLE_DONE);
    settle_d = settled ? settle_q
                       : settle_t'(settle_q + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) settle_q <= '0;
    else       settle_q <= settle_d;
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    tick_rx_ch #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .settled (settled),
      .ch_in   (ch_in[gi]),
      .tick    (tick[gi]),
      .period  (period[gi*CNT_W +: CNT_W]),
      .per_vld (per_vld[gi]),
      .stall   (stall[gi])
    );
  end

endmodule
